// File: rtl/counter_cmd_arbiter.sv
// Control arbiter for the 0-9999 counter: merges button pulses and UART commands
// into registered run/mode/clear controls and echoes each applied UART byte on TX.
module counter_cmd_arbiter #(
   parameter logic [7:0] CMD_RUN   = 8'h72,
   parameter logic [7:0] CMD_MODE  = 8'h6D,
   parameter logic [7:0] CMD_CLEAR = 8'h63,
   parameter logic [7:0] NAK_BYTE  = 8'h3F,
   parameter bit         ECHO_EN   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_r,
   input  logic       btn_d,
   input  logic       btn_l,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   output logic       run_en,
   output logic       mode_down,
   output logic       clear,
   output logic       tx_start,
   output logic [7:0] tx_data
);

   typedef enum logic {ST_STOP, ST_RUN} ctl_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_t;

   ctl_t       ctl_q, ctl_d;
   tx_t        tx_q, tx_d;
   logic       mode_q, mode_d;
   logic       clear_q, clear_d;
   logic       pend_vld_q, pend_vld_d;
   logic [7:0] pend_data_q, pend_data_d;
   logic       echo_vld_q, echo_vld_d;
   logic [7:0] echo_data_q, echo_data_d;
   logic       busy_seen_q, busy_seen_d;
   logic [7:0] tx_data_q, tx_data_d;

   logic       btn_ev, u_vld, u_known, ev_r, ev_d, ev_l, echo_pop;
   logic [7:0] u_byte;

   always_comb begin
      ctl_d       = ctl_q;
      mode_d      = mode_q;
      clear_d     = 1'b0;
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
      echo_vld_d  = echo_vld_q;
      echo_data_d = echo_data_q;
      tx_d        = tx_q;
      busy_seen_d = busy_seen_q;
      tx_data_d   = tx_data_q;
      echo_pop    = 1'b0;
      u_vld       = 1'b0;
      u_byte      = rx_data;

      // UART source: pending slot first (older byte), buttons always win the cycle
      btn_ev = btn_r | btn_d | btn_l;
      if (btn_ev) begin
         if (rx_done) begin
            pend_vld_d  = 1'b1;
            pend_data_d = rx_data;
         end
      end else if (pend_vld_q) begin
         u_vld      = 1'b1;
         u_byte     = pend_data_q;
         pend_vld_d = rx_done;
         if (rx_done) pend_data_d = rx_data;
      end else if (rx_done) begin
         u_vld = 1'b1;
      end

      u_known = (u_byte == CMD_RUN) || (u_byte == CMD_MODE) || (u_byte == CMD_CLEAR);
      ev_r = btn_r | (u_vld & (u_byte == CMD_RUN));
      ev_d = (btn_d & ~btn_r) | (u_vld & (u_byte == CMD_MODE));
      ev_l = (btn_l & ~btn_r & ~btn_d) | (u_vld & (u_byte == CMD_CLEAR));

      if (ev_r) ctl_d = (ctl_q == ST_RUN) ? ST_STOP : ST_RUN;
      if (ev_d) mode_d = ~mode_q;
      if (ev_l && ctl_q == ST_STOP) clear_d = 1'b1;

      case (tx_q)
         TX_IDLE: begin
            if (echo_vld_q && !tx_busy) begin
               tx_d      = TX_START;
               tx_data_d = echo_data_q;
               echo_pop  = 1'b1;
            end
         end
         TX_START: begin
            tx_d        = TX_WAIT;
            busy_seen_d = 1'b0;
         end
         TX_WAIT: begin
            if (!busy_seen_q) begin
               if (tx_busy) busy_seen_d = 1'b1;
            end else if (!tx_busy) begin
               tx_d = TX_IDLE;
            end
         end
         default: tx_d = TX_IDLE;
      endcase

      if (echo_pop) echo_vld_d = 1'b0;
      // a slot freed on this same edge can take the new reply; otherwise it is dropped
      if (ECHO_EN && u_vld && (!echo_vld_q || echo_pop)) begin
         echo_vld_d  = 1'b1;
         echo_data_d = u_known ? u_byte : NAK_BYTE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q       <= ST_STOP;
         mode_q      <= 1'b0;
         clear_q     <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_data_q <= 8'h00;
         echo_vld_q  <= 1'b0;
         echo_data_q <= 8'h00;
         tx_q        <= TX_IDLE;
         busy_seen_q <= 1'b0;
         tx_data_q   <= 8'h00;
      end else begin
         ctl_q       <= ctl_d;
         mode_q      <= mode_d;
         clear_q     <= clear_d;
         pend_vld_q  <= pend_vld_d;
         pend_data_q <= pend_data_d;
         echo_vld_q  <= echo_vld_d;
         echo_data_q <= echo_data_d;
         tx_q        <= tx_d;
         busy_seen_q <= busy_seen_d;
         tx_data_q   <= tx_data_d;
      end
   end

   assign run_en    = (ctl_q == ST_RUN);
   assign mode_down = mode_q;
   assign clear     = clear_q;
   assign tx_start  = (tx_q == TX_START);
   assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Bench for counter_cmd_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, and random traffic checked against a queue-based reference.
module tb_counter_cmd_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_r, btn_d, btn_l, rx_done, tx_busy;
   logic [7:0] rx_data;
   logic       run_en, mode_down, clear, tx_start;
   logic [7:0] tx_data;

   counter_cmd_arbiter dut (
      .clk(clk), .rst(rst), .btn_r(btn_r), .btn_d(btn_d), .btn_l(btn_l),
      .rx_done(rx_done), .rx_data(rx_data), .tx_busy(tx_busy),
      .run_en(run_en), .mode_down(mode_down), .clear(clear),
      .tx_start(tx_start), .tx_data(tx_data)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit         m_run, m_mode, m_clr, m_txs;
   logic [7:0] m_txd;
   logic [7:0] pend[$];
   logic [7:0] echo[$];
   int         m_ph;  // 0 idle, 1 start strobe, 2 waiting busy rise, 3 waiting busy fall

   task automatic model_reset();
      m_run = 0; m_mode = 0; m_clr = 0; m_txs = 0; m_txd = 8'h00; m_ph = 0;
      pend.delete(); echo.delete();
   endtask

   task automatic model_step(input logic r, d, l, rxd, input logic [7:0] rxdat, input logic busy);
      logic       btn, have_u;
      logic [7:0] ub;
      int         kind;  // 0 none, 1 run, 2 mode, 3 clear
      btn = r | d | l; have_u = 0; ub = 8'h00; kind = 0;
      if (btn) begin
         kind = r ? 1 : (d ? 2 : 3);
         if (rxd) begin pend.delete(); pend.push_back(rxdat); end
      end else begin
         if (pend.size() > 0) begin
            ub = pend.pop_front(); have_u = 1;
            if (rxd) pend.push_back(rxdat);
         end else if (rxd) begin
            ub = rxdat; have_u = 1;
         end
         if (have_u) kind = (ub == 8'h72) ? 1 : (ub == 8'h6D) ? 2 : (ub == 8'h63) ? 3 : 0;
      end
      m_clr = 0;
      case (kind)
         1: m_run = !m_run;
         2: m_mode = !m_mode;
         3: if (!m_run) m_clr = 1;
         default: ;
      endcase
      m_txs = 0;
      case (m_ph)
         0: if (echo.size() > 0 && !busy) begin m_txd = echo.pop_front(); m_ph = 1; m_txs = 1; end
         1: m_ph = 2;
         2: if (busy) m_ph = 3;
         default: if (!busy) m_ph = 0;
      endcase
      if (have_u && echo.size() == 0) echo.push_back(kind != 0 ? ub : 8'h3F);
   endtask

   task automatic cmp_model();
      chk("model run_en", run_en, m_run);
      chk("model mode_down", mode_down, m_mode);
      chk("model clear", clear, m_clr);
      chk("model tx_start", tx_start, m_txs);
      chk("model tx_data", tx_data, m_txd);
   endtask

   // drive at negedge, advance one clock, compare at the following negedge
   task automatic tick(input logic r, d, l, rxd, input logic [7:0] rxdat, input logic busy);
      btn_r = r; btn_d = d; btn_l = l; rx_done = rxd; rx_data = rxdat; tx_busy = busy;
      model_step(r, d, l, rxd, rxdat, busy);
      @(posedge clk);
      @(negedge clk);
      cmp_model();
   endtask

   task automatic exp5(input string nm, input logic er, em, ec, et, input logic [7:0] ed);
      chk({nm, " run_en"}, run_en, er);
      chk({nm, " mode_down"}, mode_down, em);
      chk({nm, " clear"}, clear, ec);
      chk({nm, " tx_start"}, tx_start, et);
      chk({nm, " tx_data"}, tx_data, ed);
   endtask

   task automatic do_reset();
      rst = 1; btn_r = 0; btn_d = 0; btn_l = 0; rx_done = 0; rx_data = 0; tx_busy = 0;
      model_reset();
      repeat (2) @(negedge clk);
      exp5("reset", 0, 0, 0, 0, 8'h00);
      rst = 0;
   endtask

   typedef struct {
      logic       r, d, l, rxd;
      logic [7:0] rxdat;
      logic       busy;
      logic       e_run, e_mode, e_clr, e_txs;
      logic [7:0] e_txd;
   } vec_t;

   vec_t tbl[20];
   logic [7:0] seq3[4];
   int bdly, blen;

   initial begin
      tbl[0]  = '{0,0,0,0,8'h00,0, 0,0,0,0,8'h00};
      tbl[1]  = '{1,0,0,0,8'h00,0, 1,0,0,0,8'h00};
      tbl[2]  = '{1,0,0,0,8'h00,0, 0,0,0,0,8'h00};
      tbl[3]  = '{0,1,0,0,8'h00,0, 0,1,0,0,8'h00};
      tbl[4]  = '{0,0,1,0,8'h00,0, 0,1,1,0,8'h00};
      tbl[5]  = '{0,0,0,0,8'h00,0, 0,1,0,0,8'h00};
      tbl[6]  = '{1,0,0,0,8'h00,0, 1,1,0,0,8'h00};
      tbl[7]  = '{0,0,1,0,8'h00,0, 1,1,0,0,8'h00};
      tbl[8]  = '{1,0,0,0,8'h00,0, 0,1,0,0,8'h00};
      tbl[9]  = '{0,0,0,1,8'h41,0, 0,1,0,0,8'h00};
      tbl[10] = '{0,0,0,0,8'h00,0, 0,1,0,1,8'h3F};
      tbl[11] = '{0,0,0,0,8'h00,0, 0,1,0,0,8'h3F};
      tbl[12] = '{0,0,0,0,8'h00,1, 0,1,0,0,8'h3F};
      tbl[13] = '{0,0,0,0,8'h00,0, 0,1,0,0,8'h3F};
      tbl[14] = '{1,0,1,1,8'h6D,0, 1,1,0,0,8'h3F};
      tbl[15] = '{0,0,0,0,8'h00,0, 1,0,0,0,8'h3F};
      tbl[16] = '{0,0,0,0,8'h00,0, 1,0,0,1,8'h6D};
      tbl[17] = '{0,0,0,0,8'h00,0, 1,0,0,0,8'h6D};
      tbl[18] = '{0,0,0,0,8'h00,1, 1,0,0,0,8'h6D};
      tbl[19] = '{0,0,0,0,8'h00,0, 1,0,0,0,8'h6D};

      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick(tbl[i].r, tbl[i].d, tbl[i].l, tbl[i].rxd, tbl[i].rxdat, tbl[i].busy);
         exp5($sformatf("vec%0d", i), tbl[i].e_run, tbl[i].e_mode, tbl[i].e_clr,
              tbl[i].e_txs, tbl[i].e_txd);
      end

      // UART command stream, each echo held off while tx_busy is high
      do_reset();
      seq3[0] = 8'h72; seq3[1] = 8'h72; seq3[2] = 8'h6D; seq3[3] = 8'h63;
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, 1, seq3[i], 1);
         chk($sformatf("uart%0d run_en", i), run_en, (i == 0) ? 1'b1 : 1'b0);
         chk($sformatf("uart%0d mode_down", i), mode_down, (i >= 2) ? 1'b1 : 1'b0);
         chk($sformatf("uart%0d clear", i), clear, (i == 3) ? 1'b1 : 1'b0);
         tick(0, 0, 0, 0, 8'h00, 1);
         chk($sformatf("uart%0d held off", i), tx_start, 1'b0);
         chk($sformatf("uart%0d clear drop", i), clear, 1'b0);
         tick(0, 0, 0, 0, 8'h00, 0);
         chk($sformatf("uart%0d tx_start", i), tx_start, 1'b1);
         chk($sformatf("uart%0d tx_data", i), tx_data, seq3[i]);
         tick(0, 0, 0, 0, 8'h00, 0);
         tick(0, 0, 0, 0, 8'h00, 1);
         tick(0, 0, 0, 0, 8'h00, 0);
         chk($sformatf("uart%0d single start", i), tx_start, 1'b0);
      end

      // echo overflow under a busy transmitter, then reset during TX_WAIT
      do_reset();
      tick(0, 0, 0, 1, 8'h72, 1);
      tick(0, 0, 0, 1, 8'h6D, 1);
      exp5("ovf applied", 1, 1, 0, 0, 8'h00);
      tick(0, 0, 0, 0, 8'h00, 1);
      tick(0, 0, 0, 0, 8'h00, 1);
      chk("ovf held", tx_start, 1'b0);
      tick(0, 0, 0, 0, 8'h00, 0);
      exp5("ovf first", 1, 1, 0, 1, 8'h72);
      tick(0, 0, 0, 0, 8'h00, 0);
      tick(0, 0, 0, 0, 8'h00, 1);
      rst = 1;
      #1;
      exp5("async reset", 0, 0, 0, 0, 8'h00);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      tick(0, 0, 0, 0, 8'h00, 1);
      tick(0, 0, 0, 0, 8'h00, 1);
      tick(0, 0, 0, 0, 8'h00, 0);
      tick(0, 0, 0, 0, 8'h00, 0);
      exp5("post reset", 0, 0, 0, 0, 8'h00);

      // random traffic with a transmitter that raises busy one cycle after start
      do_reset();
      bdly = 0; blen = 0;
      for (int n = 0; n < 3000; n++) begin
         logic r, d, l, rxd, busy;
         logic [7:0] b;
         int sel;
         r = ($urandom_range(0, 11) == 0);
         d = ($urandom_range(0, 11) == 0);
         l = ($urandom_range(0, 11) == 0);
         rxd = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 3);
         b = (sel == 0) ? 8'h72 : (sel == 1) ? 8'h6D : (sel == 2) ? 8'h63 : 8'($urandom);
         if (bdly > 0) begin busy = 0; bdly--; end
         else if (blen > 0) begin busy = 1; blen--; end
         else busy = ($urandom_range(0, 19) == 0);
         tick(r, d, l, rxd, b, busy);
         if (tx_start) begin bdly = 1; blen = $urandom_range(1, 6); end
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
